// File: rtl/layer_collector.sv
// Collects one FC output layer, one neuron per cycle, into a packed signed vector.
// The vector is then held stable behind a valid/ready handshake for the argmax stage.
module layer_collector #(
  parameter int SIZE     = 16,
  parameter int LAYER_SZ = 10
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [SIZE-1:0]                     in_value,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [0:LAYER_SZ-1][SIZE-1:0]       values,
  output logic                                frame_err
);

  localparam int IDX_W = (LAYER_SZ > 1) ? $clog2(LAYER_SZ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAYER_SZ - 1);
  localparam logic [SIZE-1:0]  SIZE_MIN = {1'b1, {(SIZE-1){1'b0}}};

  typedef enum logic {COLLECT, PRESENT} state_t;

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [0:LAYER_SZ-1][SIZE-1:0]   values_q, values_d;
  logic                            frame_err_q, frame_err_d;
  logic                            accept;

  assign in_ready  = (state_q == COLLECT) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == PRESENT);
  assign values    = values_q;
  assign frame_err = frame_err_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    values_d    = values_q;
    frame_err_d = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          values_d[idx_q] = in_value;
          if (idx_q == LAST_IDX) begin
            state_d     = PRESENT;
            frame_err_d = !in_last;
          end else if (in_last) begin
            // Short frame: pad the tail so padded slots can never win the argmax.
            state_d     = PRESENT;
            frame_err_d = 1'b1;
            for (int unsigned i = 0; i < LAYER_SZ; i++) begin
              if (i > 32'(idx_q)) values_d[i] = SIZE_MIN;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PRESENT: begin
        if (out_ready) begin
          state_d = COLLECT;
          idx_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      idx_q       <= '0;
      values_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      values_q    <= values_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_layer_collector.sv
// Directed bench for layer_collector: expected frames are queued as stimulus is driven
// and compared against the presented vector while out_valid is high.
module tb_layer_collector;
  localparam int SIZE     = 16;
  localparam int LAYER_SZ = 10;
  localparam int VW       = SIZE * LAYER_SZ;

  typedef logic [0:LAYER_SZ-1][SIZE-1:0] vec_t;
  typedef struct packed {
    logic err;
    vec_t v;
  } frame_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic            out_ready = 1'b1;
  logic [SIZE-1:0] in_value = '0;
  logic            in_ready, out_valid, frame_err;
  vec_t            values;

  frame_t sb[$];
  int     n_pass = 0;
  int     n_fail = 0;
  int     n_total = 0;
  int     cyc = 0;
  logic   prev_ov = 1'b0;
  logic   hs_in = 1'b0;

  int a1[LAYER_SZ] = '{5, -3, 100, 7, 0, -32768, 32767, 1, 2, -1};
  int a2[LAYER_SZ] = '{10, 20, 30, 40, 0, 0, 0, 0, 0, 0};
  int a3[LAYER_SZ] = '{-100, 200, -300, 400, -500, 600, -700, 800, -900, 1000};
  int a4[LAYER_SZ] = '{11, 12, 13, 14, 15, 16, 17, 18, 19, 20};
  int a5[LAYER_SZ] = '{7, 8, 0, 0, 0, 0, 0, 0, 0, 0};

  always #5 clk = ~clk;

  layer_collector #(.SIZE(SIZE), .LAYER_SZ(LAYER_SZ)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .values    (values),
    .frame_err (frame_err)
  );

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    if (out_valid && !prev_ov) begin
      check("frame_expected", VW'(sb.size() != 0), VW'(1));
      if (sb.size() != 0) check("frame_err_rise", VW'(frame_err), VW'(sb[0].err));
    end else begin
      check("frame_err_idle", VW'(frame_err), VW'(0));
    end
    if (out_valid && sb.size() != 0) check("values", values, sb[0].v);
    prev_ov = out_valid;
  endtask

  task automatic clk_cycle();
    logic hs_out;
    hs_out = out_valid && out_ready;
    hs_in  = in_valid && in_ready;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (hs_out && sb.size() != 0) void'(sb.pop_front());
    monitor();
  endtask

  task automatic send(input logic [SIZE-1:0] v, input logic last, input int gap);
    in_valid = 1'b0;
    repeat (gap) clk_cycle();
    in_valid = 1'b1;
    in_value = v;
    in_last  = last;
    for (int k = 0; k < 30; k++) begin
      clk_cycle();
      if (hs_in) break;
    end
    if (!hs_in) check("accept_timeout", VW'(0), VW'(1));
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int a[LAYER_SZ], input int n, input bit last_ok, input int gap);
    frame_t f;
    f.err = (n < LAYER_SZ) || !last_ok;
    for (int i = 0; i < LAYER_SZ; i++) f.v[i] = (i < n) ? SIZE'(a[i]) : 16'h8000;
    sb.push_back(f);
    for (int i = 0; i < n; i++)
      send(SIZE'(a[i]), (i == n - 1) && (last_ok || n < LAYER_SZ), (i == 0) ? 0 : gap);
  endtask

  initial begin
    int c0;
    int best;

    // Reset state
    clk_cycle();
    clk_cycle();
    check("rst_in_ready", VW'(in_ready), VW'(0));
    check("rst_out_valid", VW'(out_valid), VW'(0));
    check("rst_values", values, '0);
    check("rst_frame_err", VW'(frame_err), VW'(0));
    rst = 1'b0;
    #1;
    check("rel_in_ready", VW'(in_ready), VW'(1));

    // 1: back-to-back full frame, out_ready high
    c0 = cyc;
    send_frame(a1, LAYER_SZ, 1'b1, 0);
    check("t1_latency", VW'(cyc - c0), VW'(LAYER_SZ));
    check("t1_ov_rise", VW'(out_valid), VW'(1));
    check("t1_v6", VW'(values[6]), VW'(16'h7FFF));
    clk_cycle();
    check("t1_ov_one_cycle", VW'(out_valid), VW'(0));
    check("t1_in_ready_back", VW'(in_ready), VW'(1));
    check("t1_sb_empty", VW'(sb.size()), VW'(0));

    // 2: truncated frame padded with SIZE_MIN
    send_frame(a2, 4, 1'b1, 0);
    check("t2_ov", VW'(out_valid), VW'(1));
    best = 0;
    for (int i = 1; i < LAYER_SZ; i++)
      if ($signed(values[i]) > $signed(values[best])) best = i;
    check("t2_argmax", VW'(best), VW'(3));
    clk_cycle();
    check("t2_ov_drop", VW'(out_valid), VW'(0));

    // 3: back-pressure for 5 cycles, in_valid pulses must be ignored
    out_ready = 1'b0;
    send_frame(a3, LAYER_SZ, 1'b1, 0);
    check("t3_ov_rise", VW'(out_valid), VW'(1));
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2) == 0;
      in_value = 16'h1234;
      check("t3_in_ready_low", VW'(in_ready), VW'(0));
      clk_cycle();
      check("t3_ov_held", VW'(out_valid), VW'(1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clk_cycle();
    check("t3_transferred", VW'(out_valid), VW'(0));
    check("t3_in_ready_back", VW'(in_ready), VW'(1));
    send_frame(a5, 2, 1'b1, 0);
    clk_cycle();

    // 4: full frame with no in_last, then a clean frame
    send_frame(a4, LAYER_SZ, 1'b0, 0);
    clk_cycle();
    send_frame(a1, LAYER_SZ, 1'b1, 0);
    clk_cycle();

    // 5: gapped input
    c0 = cyc;
    send_frame(a3, LAYER_SZ, 1'b1, 1);
    check("t5_gapped_cycles", VW'(cyc - c0), VW'(2 * LAYER_SZ - 1));
    check("t5_ov", VW'(out_valid), VW'(1));
    clk_cycle();

    // 6: reset mid-frame aborts, fresh frame afterwards
    for (int i = 0; i < 6; i++) send(SIZE'(a4[i]), 1'b0, 0);
    rst = 1'b1;
    clk_cycle();
    check("t6_in_ready", VW'(in_ready), VW'(0));
    check("t6_out_valid", VW'(out_valid), VW'(0));
    check("t6_values", values, '0);
    rst = 1'b0;
    #1;
    check("t6_in_ready_rel", VW'(in_ready), VW'(1));
    send_frame(a1, LAYER_SZ, 1'b1, 0);
    check("t6_ov", VW'(out_valid), VW'(1));
    clk_cycle();
    check("t6_ov_drop", VW'(out_valid), VW'(0));
    check("sb_drained", VW'(sb.size()), VW'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
